ksa_controller: RTL
===================

# ksa_controller

Consumes the one-shot `start` pulse from the power-up start sequencer and runs the two RC4 setup phases against the 256×8 S-array RAM. Phase 1 writes the identity permutation (s[i] = i). Phase 2 runs the key-scheduling swap loop using a 24-bit secret key. It then raises `done` for the downstream PRGA/decrypt stage. It is the sole RAM master while `busy` is high.

## Interface
- `KEY_BYTES`, 3: key length in bytes. `secret_key` is KEY_BYTES×8 bits wide.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request pulse from the start sequencer.
- `secret_key`  in  24  key. Byte 0 = [23:16], byte 1 = [15:8], byte 2 = [7:0]. Must be stable while `busy`.
- `mem_addr`  out  8  S-RAM address.
- `mem_data`  out  8  S-RAM write data.
- `mem_wren`  out  1  S-RAM write enable.
- `mem_q`  in  8  S-RAM read data. Address is registered, so data is valid the cycle after the address is driven.
- `busy`  out  1  high in every state except IDLE and DONE.
- `done`  out  1  high in DONE.

## Operation
- Registers:
  - i (8b)
  - j (8b)
  - k, a 0..KEY_BYTES-1 index counter
  - si (8b)
  - sj (8b)
- State machine:
  - IDLE: outputs quiet. Start sampled high → INIT; i, j and k cleared.
  - INIT: mem_addr=i, mem_data=i, mem_wren=1.
    - i != 255: i++.
    - i == 255: i←0 and go to RD_I. i wraps to 0 naturally.
  - RD_I: mem_addr=i, no write.
  - LT_I: mem_addr=i. Latch si←mem_q and j←j+mem_q+key[k], with sum modulo 256 and 8-bit wrap.
  - RD_J: mem_addr=j, using the updated j.
  - LT_J: mem_addr=j. Latch sj←mem_q.
  - WR_I: mem_addr=i, mem_data=sj, mem_wren=1.
  - WR_J: mem_addr=j, mem_data=si, mem_wren=1.
    - k advances, wrapping KEY_BYTES-1→0.
    - i != 255: i++, go to RD_I.
    - i == 255: go to DONE.
  - DONE: done=1, outputs otherwise quiet.
    - start → INIT. i, j and k cleared; done drops the next cycle.
    - Otherwise stay in DONE.
- i == j case: WR_I then WR_J write the same address. The final value is si, which equals the original s[i]. This is correct RC4 behaviour with no special handling.
- key[k] selects byte k per the byte order above. k is independent of i; no modulo hardware on i.
- start while busy is ignored and has no effect on the sequence.
- Quiet outputs (IDLE, DONE, reset): mem_addr=0, mem_data=0, mem_wren=0, busy=0.

## Timing
- Reset values:
  - state=IDLE
  - mem_addr=0, mem_data=0, mem_wren=0
  - busy=0, done=0
  - i=j=k=0
- Reset asserted mid-operation: from the cycle after the reset edge, mem_wren=0 and state=IDLE. A new start is required; done is not asserted.
- Start sampled at the edge ending cycle t:
  - INIT occupies cycles t+1..t+256, with the write of address n in cycle t+1+n.
  - KSA occupies cycles t+257..t+1792, i.e. 256 iterations × 6 cycles.
  - done=1 from cycle t+1793.
- Per iteration: RD_I, LT_I, RD_J, LT_J, WR_I, WR_J. One write per cycle in WR_I and WR_J only.
- All outputs are registered or decoded from state only. No combinational path from mem_q or start to any output.

## Test plan
- Reset then one start pulse, key 0x000000, with a RAM model:
  - cycles 1–256 write addr n / data n with wren=1;
  - done rises exactly 1793 cycles after start is sampled;
  - final RAM matches a software RC4 KSA for key 00 00 00.
- Key 0x010000, first KSA iteration:
  - LT_I computes j=1;
  - WR_I writes addr 0 / data 0x01;
  - WR_J writes addr 1 / data 0x00.
- i==j path, key 0x000000, iteration 0: j=0, and both WR_I and WR_J write addr 0 / data 0x00. The final RAM still matches the reference model.
- Extra start pulses injected during INIT and mid-KSA: no restart, total latency still 1793, final RAM unchanged versus the first test.
- rst asserted for one cycle during KSA iteration ~100:
  - the next cycle shows mem_wren=0, busy=0, done=0;
  - a fresh start then completes correctly in 1793 cycles.
- From DONE, start with key 0x4A3B2C: done drops the next cycle, the full sequence reruns, and the final RAM matches the model for key 4A 3B 2C.

Source files
------------

// File: rtl/ksa_controller.sv
// ksa_controller: RC4 S-array setup (identity fill, then key-scheduling swaps) driving a registered-address 256x8 RAM.
module ksa_controller #(
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [KEY_BYTES*8-1:0] secret_key,
  output logic [7:0]             mem_addr,
  output logic [7:0]             mem_data,
  output logic                   mem_wren,
  input  logic [7:0]             mem_q,
  output logic                   busy,
  output logic                   done
);
  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  typedef enum logic [3:0] {IDLE, INIT, RD_I, LT_I, RD_J, LT_J, WR_I, WR_J, DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
  logic [KW-1:0] k_q, k_d;
  logic [7:0] key_bytes [KEY_BYTES];
  for (genvar g = 0; g < KEY_BYTES; g++) begin : g_key
    assign key_bytes[g] = secret_key[(KEY_BYTES-1-g)*8 +: 8];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
    end
  end
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    si_d    = si_q;
    sj_d    = sj_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = INIT;
        i_d     = '0;
        j_d     = '0;
        k_d     = '0;
      end
      INIT: begin
        i_d     = i_q + 8'd1;
        state_d = (i_q == 8'hff) ? RD_I : INIT;
      end
      RD_I: state_d = LT_I;
      LT_I: begin
        si_d    = mem_q;
        j_d     = j_q + mem_q + key_bytes[k_q];
        state_d = RD_J;
      end
      RD_J: state_d = LT_J;
      LT_J: begin
        sj_d    = mem_q;
        state_d = WR_I;
      end
      WR_I: state_d = WR_J;
      WR_J: begin
        k_d     = (k_q == KW'(KEY_BYTES-1)) ? '0 : k_q + KW'(1);
        i_d     = i_q + 8'd1;
        state_d = (i_q == 8'hff) ? DONE : RD_I;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    mem_addr = (state_q inside {INIT, RD_I, LT_I, WR_I}) ? i_q :
               (state_q inside {RD_J, LT_J, WR_J}) ? j_q : 8'd0;
    mem_data = (state_q == INIT) ? i_q : (state_q == WR_I) ? sj_q : (state_q == WR_J) ? si_q : 8'd0;
    mem_wren = state_q inside {INIT, WR_I, WR_J};
    busy     = !(state_q inside {IDLE, DONE});
    done     = state_q == DONE;
  end
endmodule
